// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full-adder slice built from two half-adder
// cells, LSB first, one bit per clock, with a start/busy/done handshake.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [WIDTH-1:0] s_nxt;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             ha1_s, ha1_c, ha2_s, ha2_c, fa_c;

    // Half-adder cell: returns {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    assign {ha1_c, ha1_s} = half_add(a_sr[0], b_sr[0]);
    assign {ha2_c, ha2_s} = half_add(ha1_s, c);
    assign fa_c           = ha1_c | ha2_c;

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at s_sr[0].
    always_comb begin
        s_nxt = (s_sr >> 1) | {ha2_s, {(WIDTH-1){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= op_a;
                        b_sr  <= op_b;
                        c     <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    s_sr <= s_nxt;
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    c    <= fa_c;
                    if (cnt == CW'(WIDTH-1)) begin
                        sum   <= s_nxt;
                        cout  <= fa_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: vector table and directed sequences at WIDTH=8,
// random operands against an arithmetic model, exhaustive pairs at WIDTH=4.
module tb_serial_add_ctrl;

    localparam int W8 = 8;
    localparam int W4 = 4;

    logic clk = 1'b0;
    logic reset;
    logic start8, busy8, done8, cout8;
    logic [W8-1:0] a8, b8, sum8;
    logic start4, busy4, done4, cout4;
    logic [W4-1:0] a4, b4, sum4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op_a(a8), .op_b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(W4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .op_a(a4), .op_b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       c;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One WIDTH=8 transaction; optionally disturbs start/op_a/op_b on RUN cycles 2 and 5.
    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] es,
                        input logic ec, input bit disturb, input string nm);
        logic [7:0] prev_s;
        logic       prev_c;
        @(negedge clk);
        prev_s = sum8;
        prev_c = cout8;
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        for (int k = 1; k <= W8 + 2; k++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (disturb && (k == 2 || k == 5)) begin
                start8 = 1'b1;
                a8 = 8'h55;
                b8 = 8'hAA;
            end
            chk($sformatf("%s busy k=%0d", nm, k), 32'(busy8), 32'(k <= W8));
            chk($sformatf("%s done k=%0d", nm, k), 32'(done8), 32'(k == W8 + 1));
            if (k <= W8) begin
                chk($sformatf("%s sum hold k=%0d", nm, k), 32'(sum8), 32'(prev_s));
                chk($sformatf("%s cout hold k=%0d", nm, k), 32'(cout8), 32'(prev_c));
            end else begin
                chk($sformatf("%s sum k=%0d", nm, k), 32'(sum8), 32'(es));
                chk($sformatf("%s cout k=%0d", nm, k), 32'(cout8), 32'(ec));
            end
        end
    endtask

    initial begin
        logic [8:0] ref9;
        logic [4:0] ref5;
        logic [7:0] ra, rb;
        int last_k, pulses, found;

        vecs[0] = '{a: 8'h01, b: 8'h01, s: 8'h02, c: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, s: 8'h00, c: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, s: 8'hFE, c: 1'b1};
        vecs[3] = '{a: 8'h80, b: 8'h80, s: 8'h00, c: 1'b1};
        vecs[4] = '{a: 8'h55, b: 8'hAA, s: 8'hFF, c: 1'b0};
        vecs[5] = '{a: 8'h00, b: 8'h00, s: 8'h00, c: 1'b0};
        vecs[6] = '{a: 8'h7F, b: 8'h01, s: 8'h80, c: 1'b0};

        reset = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 32'(busy8), 32'd0);
        chk("reset done", 32'(done8), 32'd0);
        chk("reset sum", 32'(sum8), 32'd0);
        chk("reset cout", 32'(cout8), 32'd0);
        chk("reset sum4", 32'(sum4), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++)
            add8(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, 1'b0, $sformatf("vec%0d", i));

        // Start pulses and operand changes during RUN must not disturb the result.
        add8(8'h12, 8'h34, 8'h46, 1'b0, 1'b1, "ignore");

        // Reset in the middle of RUN aborts the operation.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h3C; b8 = 8'h0F;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start8 = 1'b0;
            chk($sformatf("abort busy k=%0d", k), 32'(busy8), 32'd1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", 32'(busy8), 32'd0);
        chk("abort done", 32'(done8), 32'd0);
        chk("abort sum", 32'(sum8), 32'd0);
        chk("abort cout", 32'(cout8), 32'd0);
        found = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) found++;
        end
        chk("abort no done", 32'(found), 32'd0);
        add8(8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0, "after abort");

        // start held high: back-to-back runs every WIDTH+2 cycles.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20;
        last_k = 0;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done8) begin
                pulses++;
                chk($sformatf("held sum k=%0d", k), 32'(sum8), 32'h30);
                chk($sformatf("held cout k=%0d", k), 32'(cout8), 32'd0);
                if (last_k == 0) chk("held first done", 32'(k), 32'(W8 + 1));
                else chk($sformatf("held period k=%0d", k), 32'(k - last_k), 32'(W8 + 2));
                last_k = k;
            end
        end
        chk("held pulses", 32'(pulses), 32'd4);
        start8 = 1'b0;
        repeat (12) @(negedge clk);

        // Random operands against plain arithmetic.
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            ref9 = {1'b0, ra} + {1'b0, rb};
            repeat ($urandom_range(0, 3)) @(negedge clk);
            add8(ra, rb, ref9[7:0], ref9[8], 1'b0, $sformatf("rnd%0d", i));
        end

        // WIDTH=4: every operand pair, random idle gaps.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                ref5 = 5'(ia) + 5'(ib);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                @(negedge clk);
                start4 = 1'b1;
                a4 = 4'(ia);
                b4 = 4'(ib);
                found = 0;
                for (int k = 1; k <= 12; k++) begin
                    @(negedge clk);
                    start4 = 1'b0;
                    if (done4) begin
                        found = k;
                        break;
                    end
                end
                if (found == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL w4 timeout a=%0h b=%0h: no done within 12 cycles", ia, ib);
                end else begin
                    chk($sformatf("w4 latency a=%0h b=%0h", ia, ib), 32'(found), 32'(W4 + 1));
                    chk($sformatf("w4 result a=%0h b=%0h", ia, ib), 32'({cout4, sum4}), 32'(ref5));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
